// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding, default bus widths and the
// per-requester response payload.
package apb_pkg;

  localparam int unsigned DEF_AW     = 8;
  localparam int unsigned DEF_DW     = 8;
  // Widest read data the response payload can carry; DW must not exceed it.
  localparam int unsigned RSP_DW_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [RSP_DW_MAX-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request vector
//   advance    : the current grant is taken; move the pointer to it
//   grant      : one-hot grant (combinational), search starts at last+1
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  // First requester at or after last+1, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(last_q) + off) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found             = 1'b1;
        grant[IW'(idx)]   = 1'b1;
        gidx              = IW'(idx);
      end
    end
  end

  // Reset to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(NREQ - 1);
    end else if (advance && found) begin
      last_q <= gidx;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin picks one request, runs it through
// SETUP/ACCESS and returns read data / error to the issuing requester.
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT wait cycles.
// Ports:
//   PCLK, PRESETn           : clock, async active-low reset
//   req_valid/write/addr/wdata : packed requester inputs (i at [i*W +: W])
//   req_ready               : one-hot accept pulse (combinational)
//   rsp_valid/rsp_rdata/rsp_err : registered completion, one-hot valid
//   PSEL..PWDATA, PRDATA, PREADY, PSLVERR : APB completer bus
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [AW-1:0]      PADDR,
  output logic [DW-1:0]      PWDATA,
  input  logic [DW-1:0]      PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  apb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner_q;
  logic            any_req;
  logic            grant_en;
  logic            advance;
  logic            done;
  logic            timeout_hit;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;
  rsp_t            rsp_q;

  assign any_req   = |req_valid;
  assign advance   = grant_en && any_req;
  assign req_ready = advance ? grant : '0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  // Payload of the granted requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_write = req_write[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q;

  // Abort in the wait cycle whose increment would bring the count to TIMEOUT.
  assign timeout_hit = (state_q == ACCESS) && !PREADY && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_q <= '0;
    end else if (state_q == SETUP) begin
      tcnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (PREADY || timeout_hit);

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; arbitration is open in IDLE and in the completing ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      IDLE: begin
        grant_en = 1'b1;
        if (any_req) state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          grant_en = 1'b1;
          state_d  = any_req ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // APB outputs follow the next state; payload latches only on a grant.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      owner_q   <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
    end else begin
      PSEL      <= (state_d != IDLE);
      PENABLE   <= (state_d == ACCESS);
      rsp_valid <= done ? owner_q : '0;
      if (advance) begin
        PADDR   <= sel_addr;
        PWDATA  <= sel_wdata;
        PWRITE  <= sel_write;
        owner_q <= grant;
      end
      // PREADY wins over a simultaneous timeout.
      if (done) begin
        rsp_q.err   <= PREADY ? PSLVERR : 1'b1;
        rsp_q.rdata <= (PREADY && !PWRITE) ? RSP_DW_MAX'(PRDATA) : '0;
      end
    end
  end

  logic unused_rsp;
  assign unused_rsp = ^rsp_q.rdata;

  assign rsp_rdata = rsp_q.rdata[DW-1:0];
  assign rsp_err   = rsp_q.err;

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Multi-requester APB master that shares one APB completer bus (e.g. `decoder_wt`) between `NREQ` internal requesters. Round-robin arbitration picks one request at a time. The picked request is sequenced through the APB SETUP/ACCESS phases, and the read data and error status are returned to the requester that issued it. The block sits between the register-access clients and the APB peripheral decoders.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `AW`, 8, APB address width
- `DW`, 8, APB data width
- `TIMEOUT`, 15, max ACCESS wait cycles (used only with `APB_TIMEOUT_EN`)

Ports:
- `PCLK` in 1: the block's single clock; all logic on rising edge
- `PRESETn` in 1: reset, asynchronous, active-low
- `req_valid` in NREQ: request pending per requester
- `req_write` in NREQ: 1 = write, 0 = read
- `req_addr` in NREQ*AW: packed addresses, requester i at [i*AW +: AW]
- `req_wdata` in NREQ*DW: packed write data
- `req_ready` out NREQ: one-hot accept pulse (combinational)
- `rsp_valid` out NREQ: one-hot completion pulse (registered)
- `rsp_rdata` out DW: read data, valid with `rsp_valid`
- `rsp_err` out 1: error, valid with `rsp_valid`
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB control
- `PADDR` out AW, `PWDATA` out DW: APB address and write data
- `PRDATA` in DW, `PREADY` in 1, `PSLVERR` in 1: APB completer response

## Operation
- The FSM states are IDLE, SETUP and ACCESS; the state register is binary-encoded.
- **IDLE:**
  - If any `req_valid` is high, the arbiter grants one requester and `req_ready[g]` goes high in that cycle.
  - On the edge, `PADDR`/`PWDATA`/`PWRITE` latch from requester g, `PSEL` goes to 1 and the FSM moves to SETUP.
- **SETUP:**
  - `PENABLE` goes to 1 on the next edge and the FSM moves to ACCESS; this transition is unconditional.
- **ACCESS:**
  - All APB outputs hold until the FSM samples `PREADY`=1.
  - On that edge: `rsp_rdata` is loaded from `PRDATA` (reads only; 0 for writes), `rsp_err` is loaded from `PSLVERR`, and `rsp_valid[g]` pulses for 1 cycle.
- **Back-to-back transfers:**
  - In the completing ACCESS cycle, if any `req_valid` is high, the next grant and `req_ready` pulse happen in that same cycle.
  - The FSM then goes straight to SETUP, with `PSEL` staying 1 and `PENABLE` dropping to 0.
  - If no request is pending, the FSM goes to IDLE with `PSEL`=`PENABLE`=0.
- **Round-robin arbitration:**
  - Search starts at `last`+1 mod NREQ.
  - `last` updates only on a grant.
  - `last` resets to NREQ-1, so requester 0 wins first.
  - A non-granted requester waits at most NREQ-1 transfers.
- **Requester rules:**
  - A requester holds `req_*` stable until it sees `req_ready`.
  - A requester drops `req_valid` in the cycle after `req_ready` unless it has a new request.
- `PSLVERR` and `PRDATA` are ignored unless `PSEL`&`PENABLE`&`PREADY`.

## Timing
- **Reset values:** `PSEL`=`PENABLE`=`PWRITE`=0, `PADDR`=0, `PWDATA`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=IDLE, `last`=NREQ-1.
- **Latency:**
  - Request seen in cycle N: SETUP in N+1, ACCESS in N+2.
  - With `PREADY` high in N+2, `rsp_valid` is high in N+3.
  - Minimum of 2 APB cycles per transfer, with no idle cycle between back-to-back transfers.
- **Reset mid-transfer:** all outputs clear asynchronously, no response is produced for the in-flight request, and the requester must re-issue.
- **Simultaneous requests** in one cycle: exactly one `req_ready` bit is set, chosen per the round-robin rule.

## Configuration
- **`APB_TIMEOUT_EN` defined:**
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `PREADY`=0.
  - When the count reaches `TIMEOUT` without `PREADY`, the transfer is aborted: `rsp_valid[g]` pulses with `rsp_err`=1 and `rsp_rdata`=0, and the FSM exits ACCESS as on normal completion.
  - `PREADY` in the abort cycle is treated as normal completion, which takes precedence.
- **Not defined:** ACCESS waits indefinitely; the counter is absent and `TIMEOUT` is unused.

## Structure
- Shared package `apb_pkg` holds:
  - the `apb_state_t` enum (IDLE, SETUP, ACCESS);
  - the default `AW`/`DW` localparams;
  - the requester response struct (`rdata`, `err`).
- One sub-module, `rr_arbiter` (params NREQ; in: `req`, `advance`; out: one-hot `grant`; holds the `last` pointer).
- FSM, APB registers and the timeout counter live in the top module.

## Test plan
- Single write: req0 writes addr 8'h03 data 8'hA5, `PREADY` tied 1 → SETUP then ACCESS, `PADDR`=03, `PWDATA`=A5, `rsp_valid`=4'b0001 at N+3, `rsp_err`=0.
- Wait states and error: read addr 8'h05, `PREADY` low 3 cycles then high with `PRDATA`=8'h3C, `PSLVERR`=1 → APB outputs stable all 3 wait cycles; `rsp_rdata`=3C, `rsp_err`=1.
- Fairness: all 4 requesters held valid continuously → grant order 0,1,2,3,0, with `PSEL` never dropping between transfers.
- Reset mid-transfer: assert `PRESETn`=0 during ACCESS → `PSEL`/`PENABLE` go 0 immediately, no `rsp_valid`; after release, the next grant goes to requester 0.
- Timeout (`APB_TIMEOUT_EN`, TIMEOUT=15): `PREADY` stuck 0 → abort after 15 ACCESS cycles, with `rsp_err`=1 and `rsp_rdata`=0; without the macro the bus is still waiting at 100 cycles.
